// File: rtl/serial_mag_comparator_if.sv
// Bundle of the request, operand, cascade and result signals of the serial
// magnitude comparator. The master drives requests; the slave is the comparator.
interface serial_mag_comparator_if #(
    parameter int W = 16
);
    logic         start;
    logic         signed_mode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         eq_in;
    logic         gt_in;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;

    modport master (
        output start, signed_mode, A, B, eq_in, gt_in,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, signed_mode, A, B, eq_in, gt_in,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_mag_comparator.sv
// Serial magnitude comparator: compares two W-bit operands one K-bit digit per
// cycle, most significant digit first, with early termination on the first
// unequal digit and a cascade input used when the operands are equal.
module serial_mag_comparator #(
    parameter int W = 16,
    parameter int K = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_mag_comparator_if.slave    bus
);
    localparam int ND = W / K;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [W-1:0] MSB_MASK = W'(1) << (W - 1);

    generate
        if (K < 1 || (W % K) != 0) begin : g_bad_param
            $error("serial_mag_comparator: W must be a multiple of K and K >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          eq_in_q;
    logic          gt_in_q;
    logic [IW-1:0] idx_q;
    logic          pend_q;
    logic          last_q;
    logic          dgt_q;
    logic          dlt_q;
    logic          done_q;
    logic          eq_q;
    logic          gt_q;
    logic          lt_q;

    logic [K-1:0]  a_dig;
    logic [K-1:0]  b_dig;

    // Select the digit currently addressed by the index.
    always_comb begin
        a_dig = a_q[idx_q*K +: K];
        b_dig = b_q[idx_q*K +: K];
    end

    // Control FSM with registered results. A digit's compare flags are
    // registered in one COMPARE cycle and acted on in the next, so a
    // comparison examining D digits reports done D+1 edges after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // Signed operands are mapped to offset binary by
                        // flipping the sign bit, so every digit compares unsigned.
                        a_q     <= bus.A ^ (bus.signed_mode ? MSB_MASK : '0);
                        b_q     <= bus.B ^ (bus.signed_mode ? MSB_MASK : '0);
                        eq_in_q <= bus.eq_in;
                        gt_in_q <= bus.gt_in;
                        idx_q   <= IW'(ND - 1);
                        pend_q  <= 1'b0;
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (pend_q && (dgt_q || dlt_q)) begin
                        eq_q    <= 1'b0;
                        gt_q    <= dgt_q;
                        lt_q    <= dlt_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (pend_q && last_q) begin
                        eq_q    <= eq_in_q;
                        gt_q    <= gt_in_q & ~eq_in_q;
                        lt_q    <= ~eq_in_q & ~gt_in_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        dgt_q  <= (a_dig > b_dig);
                        dlt_q  <= (a_dig < b_dig);
                        last_q <= (idx_q == '0);
                        idx_q  <= idx_q - 1'b1;
                        pend_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;
endmodule
